// File: rtl/fifo_pkg.sv
// Helpers shared by the write-side and read-side pointer controllers of the async FIFO.
// Pointer widths up to 32 bits are covered by the 32-bit helpers.
package fifo_pkg;

   // Pointer and level width for a given address width (one wrap bit above the address).
   function automatic int lvl_w(input int addrsize);
      return addrsize + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   logic [WIDTH-1:0] w_bin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign w_bin[i] = ^i_gray[WIDTH-1:i];
   end

   assign o_bin = w_bin;

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer and status controller for the async FIFO: binary/Gray write pointers,
// registered full / almost-full / fill level computed against the synchronised read pointer, sticky overflow.
module wptr_full_lvl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = 4
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                w_req,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   input  logic [ADDRSIZE:0]   afull_thresh,
   input  logic                ovf_clr,
   output logic                w_ack,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf
);

   localparam int             PW    = lvl_w(ADDRSIZE);
   localparam logic [PW-1:0]  DEPTH = PW'(1) << ADDRSIZE;

   logic [PW-1:0] r_bin;
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] r_lvl;
   logic          r_full;
   logic          r_afull;
   logic          r_ovf;

   logic [PW-1:0] w_rbin;
   logic [PW-1:0] w_binnext;
   logic [PW-1:0] w_graynext;
   logic [PW-1:0] w_lvlnext;
   logic          w_accept;

   gray2bin #(
      .WIDTH (PW)
   ) u_rptr_g2b (
      .i_gray (wq2_rptr),
      .o_bin  (w_rbin)
   );

   // Accept / next-state: flags are computed from the post-write level so a
   // write accepted this edge is already counted when the next request arrives.
   assign w_accept   = w_req & ~r_full;
   assign w_binnext  = r_bin + PW'(w_accept);
   assign w_graynext = PW'(bin2gray(32'(w_binnext)));
   // Modular difference stays valid across pointer wrap; lagging rptr only overstates.
   assign w_lvlnext  = w_binnext - w_rbin;

   // Register stage
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         r_bin   <= '0;
         r_ptr   <= '0;
         r_lvl   <= '0;
         r_full  <= 1'b0;
         r_afull <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_bin   <= w_binnext;
         r_ptr   <= w_graynext;
         r_lvl   <= w_lvlnext;
         r_full  <= (w_lvlnext == DEPTH);
         r_afull <= (w_lvlnext >= afull_thresh);
         // A refused request sets the flag even if a clear arrives in the same cycle.
         r_ovf   <= (w_req & r_full) | (r_ovf & ~ovf_clr);
      end
   end

   assign w_ack        = w_accept;
   assign waddr        = r_bin[ADDRSIZE-1:0];
   assign wptr         = r_ptr;
   assign wfull        = r_full;
   assign walmost_full = r_afull;
   assign wlevel       = r_lvl;
   assign wovf         = r_ovf;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed bench for wptr_full_lvl with ADDRSIZE=4 (depth 16).
module tb_wptr_full_lvl;

   logic       wclk = 1'b0;
   logic       wrst;
   logic       w_req;
   logic [4:0] wq2_rptr;
   logic [4:0] afull_thresh;
   logic       ovf_clr;
   logic       w_ack;
   logic [3:0] waddr;
   logic [4:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wlevel;
   logic       wovf;

   int total = 0;
   int bad   = 0;

   wptr_full_lvl #(.ADDRSIZE(4)) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .w_req        (w_req),
      .wq2_rptr     (wq2_rptr),
      .afull_thresh (afull_thresh),
      .ovf_clr      (ovf_clr),
      .w_ack        (w_ack),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray5(input int b);
      logic [4:0] v;
      v = 5'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic test_reset();
      wrst = 1'b1; w_req = 1'b0; wq2_rptr = '0; afull_thresh = 5'd0; ovf_clr = 1'b0;
      tick(); tick();
      total++; if ({waddr, wptr, wlevel, wfull, walmost_full, wovf} !== 17'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {waddr, wptr, wlevel, wfull, walmost_full, wovf}); end
      wrst = 1'b0;
      #1;
      total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL afull_before_edge got=%b want=0", walmost_full); end
      tick();
      total++; if (walmost_full !== 1'b1) begin bad++; $display("FAIL afull_thresh0 got=%b want=1", walmost_full); end
      total++; if (wlevel !== 5'd0) begin bad++; $display("FAIL level_after_reset got=%0d want=0", wlevel); end
      afull_thresh = 5'd12;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         w_req = 1'b1;
         #1;
         total++; if (w_ack !== 1'b1) begin bad++; $display("FAIL fill_ack[%0d] got=%b want=1", i, w_ack); end
         total++; if (waddr !== 4'(i)) begin bad++; $display("FAIL fill_waddr[%0d] got=%0d want=%0d", i, waddr, i); end
         tick();
         total++; if (wlevel !== 5'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got=%0d want=%0d", i, wlevel, i + 1); end
         total++; if (wfull !== (i == 15)) begin bad++; $display("FAIL fill_full[%0d] got=%b want=%b", i, wfull, (i == 15)); end
         total++; if (walmost_full !== (i >= 11)) begin bad++; $display("FAIL fill_afull[%0d] got=%b want=%b", i, walmost_full, (i >= 11)); end
      end
      w_req = 1'b0;
      total++; if (wptr !== 5'b11000) begin bad++; $display("FAIL fill_wptr got=%b want=11000", wptr); end
   endtask

   task automatic test_overflow();
      for (int k = 0; k < 3; k++) begin
         w_req = 1'b1;
         #1;
         total++; if (w_ack !== 1'b0) begin bad++; $display("FAIL ovf_ack[%0d] got=%b want=0", k, w_ack); end
         tick();
         total++; if (wptr !== 5'b11000 || wlevel !== 5'd16 || waddr !== 4'd0) begin bad++; $display("FAIL ovf_hold[%0d] got=%b/%0d/%0d want=11000/16/0", k, wptr, wlevel, waddr); end
         total++; if (wovf !== 1'b1) begin bad++; $display("FAIL ovf_set[%0d] got=%b want=1", k, wovf); end
      end
      w_req = 1'b0; ovf_clr = 1'b1;
      tick();
      total++; if (wovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", wovf); end
      ovf_clr = 1'b0; w_req = 1'b1;
      tick();
      total++; if (wovf !== 1'b1) begin bad++; $display("FAIL ovf_reset got=%b want=1", wovf); end
      ovf_clr = 1'b1;
      tick();
      total++; if (wovf !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b want=1", wovf); end
      w_req = 1'b0;
      tick();
      total++; if (wovf !== 1'b0) begin bad++; $display("FAIL ovf_clear2 got=%b want=0", wovf); end
      ovf_clr = 1'b0;
   endtask

   task automatic test_simultaneous();
      wq2_rptr = gray5(1); w_req = 1'b1;
      #1;
      total++; if (w_ack !== 1'b0) begin bad++; $display("FAIL simul_refuse got=%b want=0", w_ack); end
      tick();
      total++; if (wfull !== 1'b0 || wlevel !== 5'd15 || wptr !== 5'b11000) begin bad++; $display("FAIL simul_drain got=%b/%0d/%b want=0/15/11000", wfull, wlevel, wptr); end
      #1;
      total++; if (w_ack !== 1'b1 || waddr !== 4'd0) begin bad++; $display("FAIL simul_accept got=%b/%0d want=1/0", w_ack, waddr); end
      tick();
      total++; if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11001) begin bad++; $display("FAIL simul_refill got=%b/%0d/%b want=1/16/11001", wfull, wlevel, wptr); end
      w_req = 1'b0;
   endtask

   task automatic test_reset_midburst();
      wrst = 1'b1; wq2_rptr = '0;
      #1;
      wrst = 1'b0; afull_thresh = 5'd5;
      for (int i = 0; i < 7; i++) begin
         w_req = 1'b1;
         tick();
      end
      total++; if (wlevel !== 5'd7 || walmost_full !== 1'b1) begin bad++; $display("FAIL mid_prefill got=%0d/%b want=7/1", wlevel, walmost_full); end
      #1; wrst = 1'b1;
      #1;
      total++; if ({waddr, wptr, wlevel, wfull, walmost_full, wovf} !== 17'd0) begin bad++; $display("FAIL mid_reset_async got=%h want=0", {waddr, wptr, wlevel, wfull, walmost_full, wovf}); end
      w_req = 1'b0;
      tick();
      wrst = 1'b0; afull_thresh = 5'd12;
      tick();
      total++; if (wlevel !== 5'd0 || waddr !== 4'd0) begin bad++; $display("FAIL mid_after_release got=%0d/%0d want=0/0", wlevel, waddr); end
   endtask

   task automatic test_almost_full();
      for (int i = 0; i < 12; i++) begin
         w_req = 1'b1;
         tick();
         if (i == 10) begin
            total++; if (walmost_full !== 1'b0 || wlevel !== 5'd11) begin bad++; $display("FAIL af_below got=%b/%0d want=0/11", walmost_full, wlevel); end
         end
      end
      w_req = 1'b0;
      total++; if (walmost_full !== 1'b1 || wlevel !== 5'd12) begin bad++; $display("FAIL af_rise got=%b/%0d want=1/12", walmost_full, wlevel); end
      wq2_rptr = gray5(1);
      tick();
      total++; if (walmost_full !== 1'b0 || wlevel !== 5'd11) begin bad++; $display("FAIL af_fall got=%b/%0d want=0/11", walmost_full, wlevel); end
      afull_thresh = 5'd17;
      for (int i = 0; i < 5; i++) begin
         w_req = 1'b1;
         tick();
         total++; if (walmost_full !== 1'b0) begin bad++; $display("FAIL af_thresh17[%0d] got=%b want=0", i, walmost_full); end
      end
      w_req = 1'b0;
      total++; if (wfull !== 1'b1 || wlevel !== 5'd16) begin bad++; $display("FAIL af_full got=%b/%0d want=1/16", wfull, wlevel); end
      afull_thresh = 5'd12;
   endtask

   task automatic test_wrap();
      int m_w, m_r, acks, cyc, lvl;
      logic exp_full, exp_ack;
      logic [4:0] prev_ptr;
      m_w = 17; m_r = 1; acks = 0; cyc = 0;
      exp_full = 1'b1;
      while (acks < 100 && cyc < 2000) begin
         w_req = (cyc % 3) != 2;
         if ((cyc % 2) == 0 && ((m_w - m_r) & 31) != 0) m_r = m_r + 1;
         wq2_rptr = gray5(m_r);
         exp_ack = w_req & ~exp_full;
         prev_ptr = wptr;
         #1;
         total++; if (w_ack !== exp_ack) begin bad++; $display("FAIL wrap_ack[%0d] got=%b want=%b", cyc, w_ack, exp_ack); end
         tick();
         if (exp_ack) begin m_w = m_w + 1; acks++; end
         lvl = (m_w - m_r) & 31;
         exp_full = (lvl == 16);
         total++; if (wlevel !== 5'(lvl)) begin bad++; $display("FAIL wrap_level[%0d] got=%0d want=%0d", cyc, wlevel, lvl); end
         total++; if (wfull !== exp_full) begin bad++; $display("FAIL wrap_full[%0d] got=%b want=%b", cyc, wfull, exp_full); end
         total++; if ($countones(wptr ^ prev_ptr) !== (exp_ack ? 1 : 0) || wptr !== gray5(m_w)) begin bad++; $display("FAIL wrap_gray[%0d] got=%b want=%b", cyc, wptr, gray5(m_w)); end
         cyc++;
      end
      w_req = 1'b0;
      total++; if (acks < 100) begin bad++; $display("FAIL wrap_budget got=%0d want=100", acks); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_simultaneous();
      test_reset_midburst();
      test_almost_full();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
